// File: rtl/uart_led_cmd.sv
// ---------------------------------------------------------------------------
// uart_led_cmd - parses ASCII "Lhh<CR>" commands into an LED register and answers OK/ER (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_led_cmd #(
  parameter logic [7:0] G_LED_RESET = 8'h00,
  parameter int         G_LF_ENABLE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_s_axis_tvalid,
  input  logic [7:0] i_s_axis_tdata,
  output logic       o_s_axis_tready,
  output logic       o_m_axis_tvalid,
  output logic [7:0] o_m_axis_tdata,
  input  logic       i_m_axis_tready,
  output logic [7:0] o_led,
  output logic       o_cmd_err
);

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [1:0] LAST_INDEX = (G_LF_ENABLE != 0) ? 2'd3 : 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    TERM = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] hi_nib, hi_nib_nxt;
  logic [3:0] lo_nib, lo_nib_nxt;
  logic [7:0] led, led_nxt;
  logic       resp_err, resp_err_nxt;
  logic [1:0] idx, idx_nxt;
  logic       cmd_err, cmd_err_nxt;
  logic       running;
  logic       in_xfer;
  logic       out_xfer;
  logic [4:0] hex;
  logic       is_cmd;
  logic [7:0] resp_byte;

  // Returns {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

  // 'running' keeps tready low until the first edge after reset release.
  assign o_s_axis_tready = running && (state != RESP);
  assign o_m_axis_tvalid = (state == RESP);
  assign o_m_axis_tdata  = resp_byte;
  assign o_led           = led;
  assign o_cmd_err       = cmd_err;

  assign in_xfer  = i_s_axis_tvalid && o_s_axis_tready;
  assign out_xfer = o_m_axis_tvalid && i_m_axis_tready;
  assign hex      = hex_decode(i_s_axis_tdata);
  assign is_cmd   = (i_s_axis_tdata == 8'h4C) || (i_s_axis_tdata == 8'h6C);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      hi_nib   <= 4'd0;
      lo_nib   <= 4'd0;
      led      <= G_LED_RESET;
      resp_err <= 1'b0;
      idx      <= 2'd0;
      cmd_err  <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hi_nib   <= hi_nib_nxt;
      lo_nib   <= lo_nib_nxt;
      led      <= led_nxt;
      resp_err <= resp_err_nxt;
      idx      <= idx_nxt;
      cmd_err  <= cmd_err_nxt;
      running  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    hi_nib_nxt   = hi_nib;
    lo_nib_nxt   = lo_nib;
    led_nxt      = led;
    resp_err_nxt = resp_err;
    idx_nxt      = idx;
    cmd_err_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (in_xfer && is_cmd) begin
          state_nxt = HI;
        end
      end
      HI, LO, TERM: begin
        if (in_xfer) begin
          if (state == HI && hex[4]) begin
            hi_nib_nxt = hex[3:0];
            state_nxt  = LO;
          end else if (state == LO && hex[4]) begin
            lo_nib_nxt = hex[3:0];
            state_nxt  = TERM;
          end else if (state == TERM && i_s_axis_tdata == CHAR_CR) begin
            led_nxt      = {hi_nib, lo_nib};
            resp_err_nxt = 1'b0;
            idx_nxt      = 2'd0;
            state_nxt    = RESP;
          end else begin
            resp_err_nxt = 1'b1;
            cmd_err_nxt  = 1'b1;
            idx_nxt      = 2'd0;
            state_nxt    = RESP;
          end
        end
      end
      RESP: begin
        if (out_xfer) begin
          if (idx == LAST_INDEX) begin
            idx_nxt   = 2'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_byte = 8'h00;
    if (state == RESP) begin
      case (idx)
        2'd0:    resp_byte = resp_err ? 8'h45 : 8'h4F;
        2'd1:    resp_byte = resp_err ? 8'h52 : 8'h4B;
        2'd2:    resp_byte = CHAR_CR;
        default: resp_byte = CHAR_LF;
      endcase
    end
  end

endmodule

`default_nettype wire
